// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Frame FSM states, scan-code prefix bytes and the odd-parity helper.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } rx_state_t;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam int         DATA_BITS = 8;

   // Odd parity holds when data bits plus parity bit contain an odd number of ones.
   function automatic logic odd_parity(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host deframer: synchroniser, clock glitch filter,
// falling-edge bit strobe, frame FSM and mid-frame inactivity timeout.
//
// state  | meaning
// IDLE   | waiting for a start bit (0) on a strobe
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking stop bit and parity, then back to IDLE
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       kbClk,
   input  logic       kbData,
   output logic [7:0] byteOut,
   output logic       byteValid,
   output logic       frameErr
);

   localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int CNT_W = $clog2(DATA_BITS);
   localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

   logic                  clk_s1, clk_s2;
   logic                  dat_s1, dat_s2;
   logic [FILTER_LEN-1:0] filt_sr;
   logic                  clk_filt, clk_filt_d;
   logic                  strobe;

   rx_state_t             state, next_state;
   logic [CNT_W-1:0]      bit_cnt;
   logic [7:0]            shift;
   logic                  par_bit;
   logic [TO_W-1:0]       to_cnt;
   logic                  timeout_hit;
   logic                  accept;
   logic                  reject;

   // Idle-high bus: everything in the input path resets to 1 so reset makes no edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1     <= 1'b1;
         clk_s2     <= 1'b1;
         dat_s1     <= 1'b1;
         dat_s2     <= 1'b1;
         filt_sr    <= '1;
         clk_filt   <= 1'b1;
         clk_filt_d <= 1'b1;
         strobe     <= 1'b0;
      end else begin
         clk_s1     <= kbClk;
         clk_s2     <= clk_s1;
         dat_s1     <= kbData;
         dat_s2     <= dat_s1;
         filt_sr    <= {filt_sr[FILTER_LEN-2:0], clk_s2};
         if (&filt_sr) begin
            clk_filt <= 1'b1;
         end else if (~|filt_sr) begin
            clk_filt <= 1'b0;
         end
         clk_filt_d <= clk_filt;
         strobe     <= clk_filt_d & ~clk_filt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A strobe takes priority over an expiring timeout in the same cycle.
   always_comb begin
      next_state  = state;
      accept      = 1'b0;
      reject      = 1'b0;
      timeout_hit = (state != IDLE) && (to_cnt == '0);
      if (strobe) begin
         case (state)
            IDLE:    if (!dat_s2) next_state = DATA;
            DATA:    if (bit_cnt == LAST_BIT) next_state = PARITY;
            PARITY:  next_state = STOP;
            STOP: begin
               next_state = IDLE;
               if (dat_s2 && odd_parity(shift, par_bit)) begin
                  accept = 1'b1;
               end else begin
                  reject = 1'b1;
               end
            end
            default: next_state = IDLE;
         endcase
      end else if (timeout_hit) begin
         next_state = IDLE;
         reject     = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt   <= '0;
         shift     <= '0;
         par_bit   <= 1'b0;
         to_cnt    <= '0;
         byteOut   <= '0;
         byteValid <= 1'b0;
         frameErr  <= 1'b0;
      end else begin
         if ((state == IDLE) || strobe) begin
            to_cnt <= TO_LOAD;
         end else if (to_cnt != '0) begin
            to_cnt <= to_cnt - 1'b1;
         end
         if (strobe) begin
            case (state)
               IDLE:    bit_cnt <= '0;
               DATA: begin
                  shift   <= {dat_s2, shift[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
               PARITY:  par_bit <= dat_s2;
               default: ;
            endcase
         end
         byteValid <= accept;
         frameErr  <= reject;
         if (accept) begin
            byteOut <= shift;
         end
      end
   end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard front end: frame receiver plus E0/F0 prefix decoder
// producing the {extended, scan code} of the currently held key.
module ps2_receiver
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       kbClk,
   input  logic       kbData,
   output logic [8:0] keyCodeOut,
   output logic       keyValid,
   output logic [7:0] byteOut,
   output logic       byteValid,
   output logic       frameErr
);

   logic       ext_pend;
   logic       brk_pend;
   logic [8:0] code;

   ps2_frame_rx #(
      .FILTER_LEN    (FILTER_LEN),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_frame_rx (
      .clk      (clk),
      .rst      (rst),
      .kbClk    (kbClk),
      .kbData   (kbData),
      .byteOut  (byteOut),
      .byteValid(byteValid),
      .frameErr (frameErr)
   );

   assign code = {ext_pend, byteOut};

   // A break only clears the held code if it releases that same key.
   always_ff @(posedge clk) begin
      if (rst) begin
         keyCodeOut <= '0;
         keyValid   <= 1'b0;
         ext_pend   <= 1'b0;
         brk_pend   <= 1'b0;
      end else begin
         keyValid <= 1'b0;
         if (frameErr) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
         end else if (byteValid) begin
            if (byteOut == PS2_EXT) begin
               ext_pend <= 1'b1;
            end else if (byteOut == PS2_BRK) begin
               brk_pend <= 1'b1;
            end else begin
               if (brk_pend) begin
                  if (code == keyCodeOut) begin
                     keyCodeOut <= '0;
                  end
               end else begin
                  keyCodeOut <= code;
                  keyValid   <= 1'b1;
               end
               ext_pend <= 1'b0;
               brk_pend <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: bit-banged PS/2 frames at a scaled bit rate,
// pulse counting on the outputs and hand-computed expected codes.
module tb_ps2_receiver;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic       kbClk  = 1'b1;
   logic       kbData = 1'b1;
   logic [8:0] keyCodeOut;
   logic       keyValid;
   logic [7:0] byteOut;
   logic       byteValid;
   logic       frameErr;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int bv_cnt   = 0;
   int fe_cnt   = 0;
   int kv_cnt   = 0;
   int bv_cyc   = 0;
   int kv_cyc   = 0;

   ps2_receiver #(
      .FILTER_LEN    (8),
      .TIMEOUT_CYCLES(200)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .kbClk     (kbClk),
      .kbData    (kbData),
      .keyCodeOut(keyCodeOut),
      .keyValid  (keyValid),
      .byteOut   (byteOut),
      .byteValid (byteValid),
      .frameErr  (frameErr)
   );

   always #10 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (byteValid) begin
         bv_cnt++;
         bv_cyc = cyc;
      end
      if (keyValid) begin
         kv_cnt++;
         kv_cyc = cyc;
      end
      if (frameErr) fe_cnt++;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input bit gl);
      kbData = b;
      if (gl) begin
         wait_cyc(5);
         kbClk = 1'b0;
         wait_cyc(3);
         kbClk = 1'b1;
         wait_cyc(12);
      end else begin
         wait_cyc(20);
      end
      kbClk = 1'b0;
      wait_cyc(20);
      kbClk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop, input bit gl);
      send_bit(1'b0, gl);
      for (int i = 0; i < 8; i++) send_bit(d[i], gl);
      send_bit((~^d) ^ bad_par, gl);
      send_bit(stop, gl);
      kbData = 1'b1;
      wait_cyc(30);
   endtask

   task automatic frame_chk(input string tag, input logic [7:0] d, input bit bad_par,
                            input logic stop, input bit gl, input int e_bv, input int e_fe,
                            input int e_kv, input logic [8:0] e_code, input logic [7:0] e_byte);
      int bv0, fe0, kv0;
      bv0 = bv_cnt;
      fe0 = fe_cnt;
      kv0 = kv_cnt;
      send_frame(d, bad_par, stop, gl);
      chk({tag, " byteValid pulses"}, bv_cnt - bv0, e_bv);
      chk({tag, " frameErr pulses"}, fe_cnt - fe0, e_fe);
      chk({tag, " keyValid pulses"}, kv_cnt - kv0, e_kv);
      chk({tag, " keyCodeOut"}, keyCodeOut, e_code);
      chk({tag, " byteOut"}, byteOut, e_byte);
   endtask

   initial begin
      int bv0, fe0, kv0;

      // reset state
      rst = 1'b1;
      wait_cyc(4);
      chk("rst keyCodeOut", keyCodeOut, 9'h000);
      chk("rst keyValid", keyValid, 1'b0);
      chk("rst byteOut", byteOut, 8'h00);
      chk("rst byteValid", byteValid, 1'b0);
      chk("rst frameErr", frameErr, 1'b0);
      rst = 1'b0;
      wait_cyc(5);

      // single make code and decode latency
      frame_chk("make5a", 8'h5A, 0, 1'b1, 0, 1, 0, 1, 9'h05A, 8'h5A);
      chk("latency bv->kv", kv_cyc - bv_cyc, 1);

      // break of the held key
      frame_chk("brk f0", 8'hF0, 0, 1'b1, 0, 1, 0, 0, 9'h05A, 8'hF0);
      frame_chk("brk 5a", 8'h5A, 0, 1'b1, 0, 1, 0, 0, 9'h000, 8'h5A);

      // extended make and break
      frame_chk("ext e0", 8'hE0, 0, 1'b1, 0, 1, 0, 0, 9'h000, 8'hE0);
      frame_chk("ext 75", 8'h75, 0, 1'b1, 0, 1, 0, 1, 9'h175, 8'h75);
      frame_chk("extb e0", 8'hE0, 0, 1'b1, 0, 1, 0, 0, 9'h175, 8'hE0);
      frame_chk("extb f0", 8'hF0, 0, 1'b1, 0, 1, 0, 0, 9'h175, 8'hF0);
      frame_chk("extb 75", 8'h75, 0, 1'b1, 0, 1, 0, 0, 9'h000, 8'h75);

      // release of a key that is not the held one
      frame_chk("mk 1c", 8'h1C, 0, 1'b1, 0, 1, 0, 1, 9'h01C, 8'h1C);
      frame_chk("oth f0", 8'hF0, 0, 1'b1, 0, 1, 0, 0, 9'h01C, 8'hF0);
      frame_chk("oth 5a", 8'h5A, 0, 1'b1, 0, 1, 0, 0, 9'h01C, 8'h5A);
      frame_chk("typematic 1c", 8'h1C, 0, 1'b1, 0, 1, 0, 1, 9'h01C, 8'h1C);

      // parity and stop-bit errors; E0 pending must be dropped by the error
      frame_chk("bad parity", 8'h5A, 1, 1'b1, 0, 0, 1, 0, 9'h01C, 8'h1C);
      frame_chk("pre e0", 8'hE0, 0, 1'b1, 0, 1, 0, 0, 9'h01C, 8'hE0);
      frame_chk("bad stop", 8'h5A, 0, 1'b0, 0, 0, 1, 0, 9'h01C, 8'hE0);
      frame_chk("after err 29", 8'h29, 0, 1'b1, 0, 1, 0, 1, 9'h029, 8'h29);

      // partial frame then silence
      bv0 = bv_cnt;
      fe0 = fe_cnt;
      send_bit(1'b0, 0);
      send_bit(1'b0, 0);
      send_bit(1'b1, 0);
      send_bit(1'b1, 0);
      kbData = 1'b1;
      wait_cyc(300);
      chk("timeout frameErr pulses", fe_cnt - fe0, 1);
      chk("timeout byteValid pulses", bv_cnt - bv0, 0);
      chk("timeout keyCodeOut", keyCodeOut, 9'h029);
      frame_chk("after timeout 16", 8'h16, 0, 1'b1, 0, 1, 0, 1, 9'h016, 8'h16);

      // short clock glitches with data low must not start a frame
      bv0 = bv_cnt;
      fe0 = fe_cnt;
      kbData = 1'b0;
      repeat (3) begin
         kbClk = 1'b0;
         wait_cyc(3);
         kbClk = 1'b1;
         wait_cyc(20);
      end
      wait_cyc(250);
      kbData = 1'b1;
      wait_cyc(5);
      chk("glitch idle frameErr", fe_cnt - fe0, 0);
      chk("glitch idle byteValid", bv_cnt - bv0, 0);
      frame_chk("glitch frame 5a", 8'h5A, 0, 1'b1, 1, 1, 0, 1, 9'h05A, 8'h5A);

      // reset in the middle of a frame
      send_bit(1'b0, 0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
      bv0 = bv_cnt;
      fe0 = fe_cnt;
      kv0 = kv_cnt;
      rst = 1'b1;
      wait_cyc(2);
      rst = 1'b0;
      chk("midrst keyCodeOut", keyCodeOut, 9'h000);
      chk("midrst byteOut", byteOut, 8'h00);
      kbData = 1'b1;
      wait_cyc(300);
      chk("midrst frameErr pulses", fe_cnt - fe0, 0);
      chk("midrst byteValid pulses", bv_cnt - bv0, 0);
      chk("midrst keyValid pulses", kv_cnt - kv0, 0);
      frame_chk("after rst 5a", 8'h5A, 0, 1'b1, 0, 1, 0, 1, 9'h05A, 8'h5A);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
